// File: rtl/ch_delay_timer.sv
// Per-channel delay timer that ends the charge/discharge sequence.
// A rising edge on the start-counter level captures the per-channel delays
// and starts a shared elapsed-cycle counter. Each channel raises its
// discharge-reset line once the counter reaches that channel's delay.
// A falling start level or an abort during a run forces a single all-ones
// flush cycle.
//
// Ports:
//   i_clk          system clock, posedge
//   i_reset_n      asynchronous active-low reset
//   i_startcounter start-counter level; only its rising edge starts a run
//   i_delay        packed per-channel delays, channel i at [i*CNT_W +: CNT_W]
//   i_abort        synchronous abort request, active high
//   o_reset_ch     per-channel discharge reset, registered
//   o_busy         run in progress
//   o_done         all channels have fired
//   o_count        elapsed-cycle counter of the current run
module ch_delay_timer #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_startcounter,
  input  logic [N_CH*CNT_W-1:0] i_delay,
  input  logic                  i_abort,
  output logic [N_CH-1:0]       o_reset_ch,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [CNT_W-1:0]      o_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DONE  = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t                  state_q, state_nx;
  logic                    start_d;
  logic [N_CH-1:0]         reset_ch_q, reset_ch_nx;
  logic                    busy_q, busy_nx;
  logic                    done_q, done_nx;
  logic [CNT_W-1:0]        count_q, count_nx;
  logic [N_CH-1:0]         fired_q, fired_nx;
  logic [CNT_W-1:0]        shadow_q  [N_CH];
  logic [CNT_W-1:0]        shadow_nx [N_CH];
  logic [N_CH-1:0]         fire;
  logic                    rise, fall;

  assign rise = i_startcounter & ~start_d;
  assign fall = ~i_startcounter & start_d;

  assign o_reset_ch = reset_ch_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_count    = count_q;

  // State and output registers
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= IDLE;
      start_d    <= 1'b0;
      reset_ch_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      count_q    <= '0;
      fired_q    <= '0;
      for (int i = 0; i < int'(N_CH); i++) shadow_q[i] <= '0;
    end else begin
      state_q    <= state_nx;
      start_d    <= i_startcounter;
      reset_ch_q <= reset_ch_nx;
      busy_q     <= busy_nx;
      done_q     <= done_nx;
      count_q    <= count_nx;
      fired_q    <= fired_nx;
      for (int i = 0; i < int'(N_CH); i++) shadow_q[i] <= shadow_nx[i];
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nx    = state_q;
    reset_ch_nx = reset_ch_q;
    busy_nx     = busy_q;
    done_nx     = done_q;
    count_nx    = count_q;
    fired_nx    = fired_q;
    fire        = '0;
    for (int i = 0; i < int'(N_CH); i++) shadow_nx[i] = shadow_q[i];

    case (state_q)
      IDLE: begin
        reset_ch_nx = '0;
        count_nx    = '0;
        busy_nx     = 1'b0;
        done_nx     = 1'b0;
        if (rise) begin
          for (int i = 0; i < int'(N_CH); i++) shadow_nx[i] = i_delay[i*CNT_W +: CNT_W];
          fired_nx = '0;
          busy_nx  = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        if (fall || i_abort) begin
          // Abort path beats firing so discharge latches always get flushed
          state_nx    = FLUSH;
          reset_ch_nx = '1;
          busy_nx     = 1'b0;
          done_nx     = 1'b0;
        end else begin
          for (int i = 0; i < int'(N_CH); i++)
            fire[i] = ~fired_q[i] & (count_q == shadow_q[i]);
          fired_nx    = fired_q | fire;
          reset_ch_nx = reset_ch_q | fire;
          // Saturate so an all-ones delay still fires
          count_nx    = (count_q == '1) ? count_q : count_q + CNT_W'(1);
          if (&fired_nx) begin
            state_nx = DONE;
            done_nx  = 1'b1;
            busy_nx  = 1'b0;
          end
        end
      end
      DONE: begin
        if (fall) begin
          state_nx    = IDLE;
          reset_ch_nx = '0;
          done_nx     = 1'b0;
          count_nx    = '0;
        end
      end
      FLUSH: begin
        state_nx    = IDLE;
        reset_ch_nx = '0;
        count_nx    = '0;
        busy_nx     = 1'b0;
        done_nx     = 1'b0;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ch_delay_timer.sv
// Directed testbench for ch_delay_timer.
module tb_ch_delay_timer;

  localparam int unsigned N_CH  = 4;
  localparam int unsigned CNT_W = 16;

  logic                  clk;
  logic                  rst_n;
  logic                  start;
  logic [N_CH*CNT_W-1:0] delay;
  logic                  abort;
  logic [N_CH-1:0]       reset_ch;
  logic                  busy;
  logic                  done;
  logic [CNT_W-1:0]      count;

  int checks = 0;
  int errors = 0;

  ch_delay_timer #(.N_CH(N_CH), .CNT_W(CNT_W)) dut (
    .i_clk          (clk),
    .i_reset_n      (rst_n),
    .i_startcounter (start),
    .i_delay        (delay),
    .i_abort        (abort),
    .o_reset_ch     (reset_ch),
    .o_busy         (busy),
    .o_done         (done),
    .o_count        (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk_idle(input string name);
    checks++;
    if (reset_ch !== 4'b0 || busy !== 1'b0 || done !== 1'b0 || count !== 16'd0) begin
      errors++;
      $display("FAIL %s got rst=%b busy=%b done=%b cnt=%0d expected all zero",
               name, reset_ch, busy, done, count);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; delay = '0;
    #3;
    chk_idle("reset_asserted");
    tick();
    #2 rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk_idle("reset_quiet");
    end
  endtask

  // Run a full sequence, checking every cycle against fire time D+1
  task automatic run_sequence(input string name, input logic [CNT_W-1:0] d3,
                              input logic [CNT_W-1:0] d2, input logic [CNT_W-1:0] d1,
                              input logic [CNT_W-1:0] d0, input int last,
                              input logic change_delay);
    int dv [4];
    logic [3:0] exp_rst;
    dv[0] = int'(d0); dv[1] = int'(d1); dv[2] = int'(d2); dv[3] = int'(d3);
    delay = {d3, d2, d1, d0};
    start = 1'b1;
    tick();  // E0
    chk({name, "_e0_busy"}, 32'(busy), 32'd1);
    chk({name, "_e0_cnt"}, 32'(count), 32'd0);
    chk({name, "_e0_rst"}, 32'(reset_ch), 32'd0);
    if (change_delay) delay = {16'd1, 16'd1, 16'd1, 16'd1};
    for (int k = 1; k <= last + 1; k++) begin
      tick();
      for (int i = 0; i < 4; i++) exp_rst[i] = (k >= dv[i] + 1);
      chk({name, "_rst"}, 32'(reset_ch), 32'(exp_rst));
      chk({name, "_done"}, 32'(done), 32'(k >= last + 1));
      chk({name, "_busy"}, 32'(busy), 32'(k < last + 1));
      if (k < last + 1) chk({name, "_cnt"}, 32'(count), 32'(k));
    end
    start = 1'b0;
    tick();
    chk_idle({name, "_fall_idle"});
  endtask

  task automatic test_distinct();
    run_sequence("distinct", 16'd12, 16'd0, 16'd5, 16'd3, 12, 1'b0);
  endtask

  task automatic test_simultaneous();
    run_sequence("simul", 16'd7, 16'd7, 16'd7, 16'd7, 7, 1'b0);
  endtask

  task automatic test_abort();
    delay = {16'd100, 16'd100, 16'd2, 16'd50};
    start = 1'b1;
    tick();  // E0
    for (int k = 1; k <= 9; k++) tick();
    chk("abort_pre_rst", 32'(reset_ch), 32'h2);
    chk("abort_pre_cnt", 32'(count), 32'd9);
    abort = 1'b1;
    tick();  // E0+10
    abort = 1'b0;
    chk("abort_flush_rst", 32'(reset_ch), 32'hF);
    chk("abort_flush_busy", 32'(busy), 32'd0);
    chk("abort_flush_done", 32'(done), 32'd0);
    tick();
    chk_idle("abort_idle");
    for (int k = 0; k < 5; k++) begin
      tick();
      chk_idle("abort_stay_idle");
    end
    start = 1'b0;
    tick();
    chk_idle("abort_release");
  endtask

  task automatic test_fall_rearm();
    delay = {16'd40, 16'd40, 16'd40, 16'd40};
    start = 1'b1;
    tick();  // E0
    for (int k = 1; k <= 19; k++) tick();
    chk("rearm_run_cnt", 32'(count), 32'd19);
    start = 1'b0;
    tick();
    chk("rearm_flush_rst", 32'(reset_ch), 32'hF);
    chk("rearm_flush_busy", 32'(busy), 32'd0);
    tick();
    chk_idle("rearm_idle");
    tick();
    tick();
    run_sequence("rearm", 16'd4, 16'd3, 16'd2, 16'd1, 4, 1'b0);
  endtask

  task automatic test_back_to_back_async();
    delay = {16'd30, 16'd30, 16'd30, 16'd30};
    start = 1'b1;
    tick();
    tick();
    tick();
    chk("async_pre_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_idle("async_immediate");
    start = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    chk_idle("async_after");
  endtask

  task automatic test_shadow();
    run_sequence("shadow", 16'd6, 16'd4, 16'd2, 16'd8, 8, 1'b1);
  endtask

  initial begin
    test_reset();
    test_distinct();
    test_simultaneous();
    test_abort();
    test_fall_rearm();
    test_back_to_back_async();
    test_shadow();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ch_delay_timer.md
Name: ch_delay_timer

Overview:
- Per-channel delay timer that closes the charge/discharge sequence.
- Sits downstream of the first-charge/discharge controller. It consumes that controller's start-counter output and drives the controller's per-channel discharge-reset inputs.
- On start, each channel counts its own programmed delay. When the count is reached, the channel's reset line is asserted, which terminates that channel's discharge and defines the output delay.

Parameters:
- N_CH, 4, number of delay channels (one reset line per channel)
- CNT_W, 16, width of each channel delay value and of the elapsed counter

Ports:
- i_clk  input  1  system clock; all state is updated on posedge
- i_reset_n  input  1  asynchronous, active-low reset
- i_startcounter  input  1  start-counter level from the charge controller; only its rising edge starts a run
- i_delay  input  N_CH*CNT_W  packed per-channel delays in clock cycles; channel i occupies bits [i*CNT_W +: CNT_W]
- i_abort  input  1  synchronous abort request, active high
- o_reset_ch  output  N_CH  per-channel discharge reset, registered, active high
- o_busy  output  1  high while a run is in progress (state RUN)
- o_done  output  1  high once all channels have fired, until the sequence returns to idle
- o_count  output  CNT_W  elapsed-cycle counter of the current run

Behaviour:
- Reset: while i_reset_n is low, all registers clear immediately, independent of the clock.
  - State = IDLE, o_reset_ch = 0, o_busy = 0, o_done = 0, o_count = 0.
  - Shadow delays = 0, fired flags = 0, start_d = 0.
  - Assertion mid-run aborts the run with no flush cycle.
- Edge detect:
  - start_d is a register holding the previous-cycle sample of i_startcounter.
  - rise = i_startcounter & ~start_d.
  - fall = ~i_startcounter & start_d.
- States: IDLE, RUN, DONE, FLUSH.
- IDLE:
  - Outputs: o_reset_ch = 0, o_count = 0.
  - On rise at edge E0: capture i_delay into the shadow registers, clear the fired flags, counter <= 0, state <= RUN.
- RUN:
  - o_busy = 1. o_count increments by 1 per cycle and saturates at all-ones (no wrap).
  - Each cycle, for every channel with fired[i] = 0 and counter == shadow[i]: fired[i] <= 1 and o_reset_ch[i] <= 1 on that same edge.
  - Latency: a channel with delay D drives o_reset_ch[i] high after edge E0+1+D.
    - D = 0 goes high after E0+1.
    - Channels with equal delays fire on the same edge.
  - Once set, o_reset_ch[i] stays high until the run leaves DONE or FLUSH.
  - When the last unfired channel fires: state <= DONE, o_done <= 1, o_busy <= 0.
  - fall or i_abort takes priority over firing: state <= FLUSH and o_reset_ch <= all ones on that edge.
  - Changes on i_delay during RUN are ignored (shadowed).
- DONE:
  - o_done = 1 and o_reset_ch = all ones.
  - The counter holds its last value.
  - On fall: state <= IDLE, and o_reset_ch, o_done and the counter clear on that edge.
  - i_abort in DONE has no effect. rise cannot occur in DONE.
- FLUSH:
  - Exactly one cycle with o_reset_ch = all ones, o_busy = 0, o_done = 0.
  - This guarantees the controller's discharge latches are cleared on an aborted run.
  - Next edge: state <= IDLE, o_reset_ch <= 0, counter <= 0.
  - A rise seen in FLUSH is dropped; a new run needs a fresh rise from IDLE.
- i_abort in IDLE: ignored.
- Saturation: a delay of all-ones fires when the counter reaches all-ones. The counter never wraps, so every channel always fires.
- All outputs are registered; no combinational path from any input to any output.

Test Plan:
- Reset behaviour: i_reset_n low, then release; hold i_startcounter = 0 -> all outputs 0, state IDLE; no activity for 20 cycles.
- Distinct delays: i_delay = {12, 0, 5, 3} (ch3..ch0); rise at E0 ->
  - ch1 high after E0+1, ch0 after E0+4, ch2 after E0+6, ch3 after E0+13.
  - o_done high after E0+13; o_busy low from the same edge.
  - i_startcounter low -> o_reset_ch = 0 one edge later.
- Simultaneous fire: all delays = 7 -> all four o_reset_ch bits and o_done rise together after E0+8.
- Abort mid-run: delays = {100, 100, 2, 50}; i_abort pulse at E0+10 ->
  - o_reset_ch = 4'b1111 for exactly one cycle, then 0.
  - o_busy drops; o_done never asserts.
- Falling start and re-arm: i_startcounter drops at E0+20 with delays {40, 40, 40, 40} -> FLUSH then IDLE; a new rise 3 cycles later restarts with freshly captured delays and o_count from 0.
- Async reset and delay shadowing:
  - Async reset asserted mid-cycle during RUN -> outputs 0 immediately, without waiting for a clock edge.
  - Separate run: change i_delay during RUN -> fire times follow the values captured at E0.
